// File: rtl/csi2_packet_transmitter.sv
// Single-lane CSI-2 packetizer: FS, one RAW10 long packet per line, FE.
// Header ECC and per-line payload CRC-16 are generated inline.
`timescale 1ns/1ps
module csi2_packet_transmitter #(
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0,
  parameter logic [5:0] DATA_TYPE       = 6'h2B,
  parameter int         GAP_CYCLES      = 16
) (
  input  logic        mipi_byte_clock,
  input  logic        mipi_byte_reset_n,
  input  logic        start_frame_in,
  input  logic [10:0] x_size_in,
  input  logic [10:0] y_size_in,
  input  logic [9:0]  pixel_data_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  output logic        hs_request_out,
  output logic [7:0]  byte_data_out,
  output logic        byte_valid_out,
  input  logic        hs_ready_in,
  output logic        busy_out,
  output logic        frame_done_out
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FS   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_CRC  = 3'd5;
  localparam logic [2:0] S_FE   = 3'd6;

  logic [2:0]       state;
  logic [8:0]       x_groups;
  logic [10:0]      y_lines;
  logic [11:0]      line_cnt;
  logic [9:0]       grp_cnt;
  logic [2:0]       byte_idx;
  logic [1:0]       pix_cnt;
  logic             emitting;
  logic             fe_sent;
  logic [3:0][9:0]  pix;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic [15:0]      frame_number;
  logic [GW-1:0]    gap_cnt;
  logic             frame_done;

  logic in_idle, in_fs, in_fe, in_hdr, in_pay, in_crc, in_gap;
  logic hdr_fmt, byte_acc, pix_acc, last_group, more_lines;
  logic [7:0]  hdr_di;
  logic [15:0] hdr_wc;
  logic [15:0] long_wc;
  logic [7:0]  byte_mux;
  logic        unused_bits;

  assign unused_bits = ^x_size_in[1:0];

  function automatic logic [7:0] ecc_of(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^{d[0], d[1], d[2], d[4], d[5], d[7], d[10], d[11],
             d[13], d[16], d[20], d[21], d[22], d[23]};
    p[1] = ^{d[0], d[1], d[3], d[4], d[6], d[8], d[10], d[12],
             d[14], d[17], d[20], d[21], d[22], d[23]};
    p[2] = ^{d[0], d[2], d[3], d[5], d[6], d[9], d[11], d[12],
             d[15], d[18], d[20], d[21], d[22]};
    p[3] = ^{d[1], d[2], d[3], d[7], d[8], d[9], d[13], d[14],
             d[15], d[19], d[20], d[21], d[23]};
    p[4] = ^{d[4], d[5], d[6], d[7], d[8], d[9], d[16], d[17],
             d[18], d[19], d[20], d[22], d[23]};
    p[5] = ^{d[10], d[11], d[12], d[13], d[14], d[15], d[16],
             d[17], d[18], d[19], d[21], d[22], d[23]};
    return {2'b00, p};
  endfunction

  assign in_idle = state == S_IDLE;
  assign in_fs   = state == S_FS;
  assign in_fe   = state == S_FE;
  assign in_hdr  = state == S_HDR;
  assign in_pay  = state == S_PAY;
  assign in_crc  = state == S_CRC;
  assign in_gap  = state == S_GAP;
  assign hdr_fmt = in_fs | in_fe | in_hdr;

  assign long_wc = {5'd0, x_groups, 2'b00} + {7'd0, x_groups};

  assign pixel_ready_out = in_pay & ~emitting;
  assign byte_valid_out  = hdr_fmt | in_crc | (in_pay & emitting);
  assign hs_request_out  = hdr_fmt | in_pay | in_crc;
  assign busy_out        = ~in_idle;
  assign frame_done_out  = frame_done;
  assign byte_data_out   = byte_valid_out ? byte_mux : 8'h00;

  assign byte_acc   = byte_valid_out & hs_ready_in;
  assign pix_acc    = pixel_ready_out & pixel_valid_in;
  assign last_group = (grp_cnt + 10'd1) == {1'b0, x_groups};
  assign more_lines = (x_groups != 9'd0) &&
                      (line_cnt < {1'b0, y_lines});

  always_comb begin
    hdr_di = {VIRTUAL_CHANNEL, 6'h00};
    hdr_wc = frame_number;
    unique case (1'b1)
      in_fe: hdr_di = {VIRTUAL_CHANNEL, 6'h01};
      in_hdr: begin
        hdr_di = {VIRTUAL_CHANNEL, DATA_TYPE};
        hdr_wc = long_wc;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_mux = 8'h00;
    unique case (1'b1)
      hdr_fmt: begin
        case (byte_idx)
          3'd0:    byte_mux = hdr_di;
          3'd1:    byte_mux = hdr_wc[7:0];
          3'd2:    byte_mux = hdr_wc[15:8];
          default: byte_mux = ecc_of({hdr_wc, hdr_di});
        endcase
      end
      in_pay: begin
        if (byte_idx == 3'd4)
          byte_mux = {pix[3][1:0], pix[2][1:0],
                      pix[1][1:0], pix[0][1:0]};
        else
          byte_mux = pix[byte_idx[1:0]][9:2];
      end
      in_crc: byte_mux = byte_idx[0] ? crc[15:8] : crc[7:0];
      default: ;
    endcase
  end

  // Reflected CRC-16/0x8408, one byte per accepted payload beat.
  always_comb begin
    crc_next = crc ^ {8'h00, byte_mux};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ 16'h8408)
                             : (crc_next >> 1);
  end

  always_ff @(posedge mipi_byte_clock or negedge mipi_byte_reset_n) begin
    if (!mipi_byte_reset_n) begin
      state        <= S_IDLE;
      x_groups     <= '0;
      y_lines      <= '0;
      line_cnt     <= '0;
      grp_cnt      <= '0;
      byte_idx     <= '0;
      pix_cnt      <= '0;
      emitting     <= 1'b0;
      fe_sent      <= 1'b0;
      pix          <= '0;
      crc          <= 16'hFFFF;
      frame_number <= 16'd1;
      gap_cnt      <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (1'b1)
        in_idle: if (start_frame_in) begin
          x_groups <= x_size_in[10:2];
          y_lines  <= y_size_in;
          line_cnt <= '0;
          byte_idx <= '0;
          fe_sent  <= 1'b0;
          state    <= S_FS;
        end
        in_fs, in_fe: if (byte_acc) begin
          if (byte_idx == 3'd3) begin
            byte_idx <= '0;
            gap_cnt  <= GW'(GAP_CYCLES - 1);
            state    <= S_GAP;
            if (in_fe) begin
              fe_sent      <= 1'b1;
              frame_number <= (frame_number == 16'hFFFF) ? 16'd1
                              : frame_number + 16'd1;
            end
          end else begin
            byte_idx <= byte_idx + 3'd1;
          end
        end
        in_hdr: if (byte_acc) begin
          if (byte_idx == 3'd3) begin
            byte_idx <= '0;
            grp_cnt  <= '0;
            pix_cnt  <= '0;
            emitting <= 1'b0;
            crc      <= 16'hFFFF;
            state    <= S_PAY;
          end else begin
            byte_idx <= byte_idx + 3'd1;
          end
        end
        in_pay: begin
          if (!emitting) begin
            if (pix_acc) begin
              pix[pix_cnt] <= pixel_data_in;
              pix_cnt      <= pix_cnt + 2'd1;
              if (pix_cnt == 2'd3) begin
                emitting <= 1'b1;
                byte_idx <= '0;
              end
            end
          end else if (byte_acc) begin
            crc <= crc_next;
            if (byte_idx == 3'd4) begin
              byte_idx <= '0;
              emitting <= 1'b0;
              grp_cnt  <= grp_cnt + 10'd1;
              if (last_group) state <= S_CRC;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        in_crc: if (byte_acc) begin
          if (byte_idx[0]) begin
            byte_idx <= '0;
            line_cnt <= line_cnt + 12'd1;
            gap_cnt  <= GW'(GAP_CYCLES - 1);
            state    <= S_GAP;
          end else begin
            byte_idx <= 3'd1;
          end
        end
        in_gap: begin
          if (gap_cnt == '0) begin
            if (fe_sent) begin
              fe_sent    <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else if (more_lines) begin
              state <= S_HDR;
            end else begin
              state <= S_FE;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_packet_transmitter.sv
// Self-checking bench: random pixels and throttling, compared against a
// frame-level byte model built from the CSI-2 packet rules.
`timescale 1ns/1ps
module tb_csi2_packet_transmitter;

  localparam int GAP = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] xs = '0;
  logic [10:0] ys = '0;
  logic [9:0]  pdata = '0;
  logic        pvalid = 1'b0;
  logic        hs_ready = 1'b0;
  logic        pready, hs_req, bvalid, busy, done;
  logic [7:0]  bdata;

  always #5 clk = ~clk;

  csi2_packet_transmitter dut (
    .mipi_byte_clock   (clk),
    .mipi_byte_reset_n (rst_n),
    .start_frame_in    (start),
    .x_size_in         (xs),
    .y_size_in         (ys),
    .pixel_data_in     (pdata),
    .pixel_valid_in    (pvalid),
    .pixel_ready_out   (pready),
    .hs_request_out    (hs_req),
    .byte_data_out     (bdata),
    .byte_valid_out    (bvalid),
    .hs_ready_in       (hs_ready),
    .busy_out          (busy),
    .frame_done_out    (done)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  int unsigned fn = 1;
  bit          use_preset = 0;
  logic [9:0]  pix_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  ref_q[$];
  logic [5:0]  ecc_tab[24];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ECC as the XOR of each set data bit's column code.
  function automatic logic [7:0] m_ecc(input logic [7:0] di,
                                       input logic [15:0] wc);
    logic [23:0] d;
    logic [5:0]  e;
    d = {wc, di};
    e = '0;
    for (int i = 0; i < 24; i++)
      if (d[i]) e = e ^ ecc_tab[i];
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] m_crc(input logic [7:0] b[$]);
    bit          bits[$];
    logic [15:0] r;
    logic        fb;
    r = 16'hFFFF;
    foreach (b[k])
      for (int i = 0; i < 8; i++) bits.push_back(b[k][i]);
    foreach (bits[k]) begin
      fb = r[0] ^ bits[k];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic push_hdr(input logic [7:0] di, input logic [15:0] wc);
    exp_q.push_back(di);
    exp_q.push_back(wc[7:0]);
    exp_q.push_back(wc[15:8]);
    exp_q.push_back(m_ecc(di, wc));
  endtask

  task automatic build_exp(input int xe, input int y, input int npix);
    logic [7:0]  pay[$];
    logic [7:0]  lsb;
    logic [15:0] c;
    int          pi;
    pi = 0;
    exp_q.delete();
    push_hdr(8'h00, 16'(fn));
    if (npix > 0) begin
      for (int l = 0; l < y; l++) begin
        pay.delete();
        for (int g = 0; g < xe / 4; g++) begin
          lsb = '0;
          for (int k = 0; k < 4; k++) begin
            pay.push_back(8'(pix_q[pi + k] >> 2));
            lsb = lsb | (8'(pix_q[pi + k] & 10'h3) << (2 * k));
          end
          pay.push_back(lsb);
          pi += 4;
        end
        push_hdr(8'h2B, 16'(xe * 5 / 4));
        foreach (pay[i]) exp_q.push_back(pay[i]);
        c = m_crc(pay);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
      end
    end
    push_hdr(8'h01, 16'(fn));
  endtask

  task automatic run_frame(input string name, input int x, input int y,
                           input bit thr, input int busy_start_at,
                           input int abort_at);
    int         xe, npix, pi, cyc, low_run, bad;
    bit         seen_hs, stall, fin, aborted;
    logic [7:0] held;
    string      t;
    xe = (x / 4) * 4;
    npix = (xe >= 4 && y > 0) ? xe * y : 0;
    pi = 0; cyc = 0; low_run = 0;
    seen_hs = 0; stall = 0; fin = 0; aborted = 0; held = '0;
    pix_q.delete();
    for (int i = 0; i < npix; i++) pix_q.push_back(10'($urandom));
    if (use_preset && npix >= 4) begin
      pix_q[0] = 10'h3FF; pix_q[1] = 10'h000;
      pix_q[2] = 10'h155; pix_q[3] = 10'h2AA;
    end
    build_exp(xe, y, npix);
    got_q.delete();
    chk({name, " idle before start"}, busy, 1'b0);
    @(negedge clk);
    start = 1'b1; xs = 11'(x); ys = 11'(y);
    hs_ready = 1'b0; pvalid = 1'b0;
    while (!fin && cyc < 40000) begin
      @(negedge clk);
      start = (cyc == busy_start_at);
      if (start) begin
        xs = 11'($urandom); ys = 11'($urandom_range(1, 3));
      end
      if (cyc == 0)
        chk({name, " busy/hs rise"}, {busy, hs_req}, 2'b11);
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({name, " outputs at reset"},
            {busy, hs_req, bvalid, pready, done, bdata}, '0);
        aborted = 1; fin = 1;
      end else begin
        if (stall)
          chk({name, " held byte"}, {bvalid, bdata}, {1'b1, held});
        chk({name, " valid outside burst"}, bvalid & ~hs_req, 1'b0);
        chk({name, " ready outside payload"},
            pready & ~(hs_req & ~bvalid), 1'b0);
        if (done) begin
          chk({name, " gap before done"}, low_run, GAP);
          fin = 1;
        end
        if (hs_req) begin
          if (seen_hs && low_run > 0)
            chk({name, " gap length"}, low_run, GAP);
          seen_hs = 1; low_run = 0;
        end else begin
          low_run++;
        end
        hs_ready = thr ? ($urandom_range(0, 3) != 0) : 1'b1;
        pvalid = thr ? ($urandom_range(0, 2) != 0) : 1'b1;
        pdata = (pi < npix) ? pix_q[pi] : 10'($urandom);
        stall = bvalid && !hs_ready;
        held = bdata;
        if (bvalid && hs_ready) got_q.push_back(bdata);
        if (pready && pvalid) pi++;
      end
      cyc++;
    end
    start = 1'b0; pvalid = 1'b0; hs_ready = 1'b0;
    chk({name, " finished"}, fin, 1'b1);
    if (aborted) begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      fn = 1;
      @(negedge clk);
    end else begin
      @(negedge clk);
      chk({name, " done one cycle"}, {done, busy}, 2'b00);
      chk({name, " pixels taken"}, pi, npix);
      chk({name, " byte count"}, got_q.size(), exp_q.size());
      bad = -1;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
        if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
      t = "";
      if (bad >= 0)
        t = $sformatf(" (got %02h want %02h)", got_q[bad], exp_q[bad]);
      chk({name, " first differing byte index", t}, bad, -1);
      fn = (fn == 65535) ? 1 : fn + 1;
    end
  endtask

  initial begin
    ecc_tab = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    ref_q = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
              8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
              8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
    repeat (3) @(negedge clk);
    chk("reset outputs", {busy, hs_req, bvalid, pready, done, bdata}, '0);
    rst_n = 1'b1;
    chk("model crc reference", m_crc(ref_q), 16'h00F0);

    use_preset = 1;
    run_frame("f1 8x2", 8, 2, 0, -1, -1);
    use_preset = 0;
    chk("f1 FS bytes", {got_q[0], got_q[1], got_q[2], got_q[3]},
        32'h0001001A);
    chk("f1 line header", {got_q[4], got_q[5], got_q[6], got_q[7]},
        32'h2B0A002E);
    chk("f1 payload msb", {got_q[8], got_q[9], got_q[10], got_q[11]},
        32'hFF0055AA);
    chk("f1 payload lsb", got_q[12], 8'h93);
    chk("f1 FE bytes", {got_q[36], got_q[37], got_q[38], got_q[39]},
        32'h0101001D);

    run_frame("f2 512x4", 512, 4, 0, -1, -1);
    run_frame("f3 512x4 throttled", 512, 4, 1, -1, -1);
    run_frame("f4 x=3", 3, 5, 0, -1, -1);
    run_frame("f5 y=0", 64, 0, 0, -1, -1);
    run_frame("f6 start while busy", 16, 3, 0, 50, -1);
    for (int i = 0; i < 4; i++)
      run_frame($sformatf("rnd%0d", i), $urandom_range(0, 40),
                $urandom_range(0, 3), 1, -1, -1);

    run_frame("abort mid payload", 16, 2, 0, -1, 12);
    run_frame("after reset", 8, 1, 0, -1, -1);
    chk("frame number after reset", {got_q[1], got_q[2]}, 16'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
